// File: rtl/ray_march_ctrl.sv
// Sphere-tracing controller: marches one ray at a time through the SDF stage and
// reports hit/miss, travelled distance and step count. vec3 component index 0 = x.
module ray_march_ctrl #(
    parameter int                 MAX_STEPS = 64,
    parameter int                 STEP_W    = 7,
    parameter logic signed [31:0] HIT_EPS   = 32'sh0000_0041,
    parameter logic signed [31:0] MAX_DIST  = 32'sh0040_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ray_valid,
    output logic                   ray_ready,
    input  logic [2:0][31:0]       ray_origin,
    input  logic [2:0][31:0]       ray_dir,
    output logic [2:0][31:0]       sdf_point,
    output logic                   sdf_valid,
    input  logic [31:0]            sdf_dist,
    input  logic                   sdf_dist_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_hit,
    output logic [31:0]            res_t,
    output logic [STEP_W-1:0]      res_steps
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

    state_t                state, state_next;
    logic [2:0][31:0]      origin_q, dir_q, point_next;
    logic signed [31:0]    t_q, dist_q, t_new;
    logic [STEP_W-1:0]     steps_q;
    logic signed [32:0]    t_sum;
    logic                  is_hit, over_dist, at_limit;

    // Q16.16 multiply, truncating the fractional bits below the result LSB.
    function automatic logic signed [31:0] fp_mul(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return 32'(p >>> 16);
    endfunction

    always_comb begin
        is_hit    = dist_q < HIT_EPS;
        t_sum     = {t_q[31], t_q} + {dist_q[31], dist_q};
        t_new     = (t_sum > 33'sh0_7FFF_FFFF) ? 32'sh7FFF_FFFF : t_sum[31:0];
        over_dist = t_new > MAX_DIST;
        at_limit  = steps_q == STEP_W'(MAX_STEPS);
        for (int c = 0; c < 3; c++) begin
            point_next[c] = origin_q[c] + fp_mul(dir_q[c], t_new);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ray_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (sdf_dist_valid) state_next = UPDATE;
            UPDATE:  state_next = (is_hit || over_dist || at_limit) ? DONE : ISSUE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ray_ready = (state == IDLE);
        sdf_valid = (state == ISSUE);
        res_valid = (state == DONE);
    end

    // A hit keeps the t reached before the final sample; misses report the overshoot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_q  <= '0;
            dir_q     <= '0;
            t_q       <= '0;
            dist_q    <= '0;
            steps_q   <= '0;
            sdf_point <= '0;
            res_hit   <= 1'b0;
            res_t     <= '0;
            res_steps <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ray_valid) begin
                        origin_q  <= ray_origin;
                        dir_q     <= ray_dir;
                        t_q       <= '0;
                        steps_q   <= '0;
                        sdf_point <= ray_origin;
                    end
                end
                WAIT: begin
                    if (sdf_dist_valid) begin
                        dist_q  <= sdf_dist;
                        steps_q <= steps_q + 1'b1;
                    end
                end
                UPDATE: begin
                    if (is_hit) begin
                        res_hit   <= 1'b1;
                        res_t     <= t_q;
                        res_steps <= steps_q;
                    end else begin
                        t_q <= t_new;
                        if (over_dist || at_limit) begin
                            res_hit   <= 1'b0;
                            res_t     <= t_new;
                            res_steps <= steps_q;
                        end else begin
                            sdf_point <= point_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Self-checking bench for ray_march_ctrl: directed table rows, hand-written corner
// sequences and random rays checked against a step-by-step sphere-tracing model.
module tb_ray_march_ctrl;

    localparam int     MAX_STEPS  = 4;
    localparam int     STEP_W     = 7;
    localparam longint HIT_EPS_L  = 64'h41;
    localparam longint MAX_DIST_L = 64'h40_0000;
    localparam longint SAT_L      = 64'h7FFF_FFFF;

    typedef logic [2:0][31:0] vec3_t;
    typedef logic [3:0][31:0] dist4_t;

    typedef struct {
        vec3_t       origin;
        vec3_t       dir;
        dist4_t      dists;
        int          lat;
        logic        hit;
        logic [31:0] t;
        int          steps;
    } vec_t;

    logic              clk, rst_n;
    logic              ray_valid, ray_ready;
    vec3_t             ray_origin, ray_dir, sdf_point;
    logic              sdf_valid;
    logic [31:0]       sdf_dist;
    logic              sdf_dist_valid;
    logic              res_valid, res_ready, res_hit;
    logic [31:0]       res_t;
    logic [STEP_W-1:0] res_steps;

    int          checks, passes, strobes;
    vec3_t       obs_pts[$];
    vec3_t       exp_pts[$];
    logic        got_hit;
    logic [31:0] got_t;
    int          got_steps;
    vec_t        tbl[7];

    ray_march_ctrl #(.MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_origin(ray_origin), .ray_dir(ray_dir),
        .sdf_point(sdf_point), .sdf_valid(sdf_valid),
        .sdf_dist(sdf_dist), .sdf_dist_valid(sdf_dist_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_t(res_t), .res_steps(res_steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec3_t v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic dist4_t d4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic tick();
        @(negedge clk);
        if (sdf_valid) strobes++;
    endtask

    function automatic vec3_t point_at(input vec3_t o, input vec3_t d, input longint t);
        vec3_t  p;
        longint m;
        for (int c = 0; c < 3; c++) begin
            m    = (longint'($signed(d[c])) * t) >>> 16;
            p[c] = o[c] + m[31:0];
        end
        return p;
    endfunction

    // Reference sphere tracer: the rules applied one sample at a time on wide integers.
    task automatic model_ray(input vec3_t origin, input vec3_t dir, input dist4_t dists,
                             output logic hit, output logic [31:0] t_out, output int steps);
        longint t, tn, d;
        bit     fin;
        exp_pts.delete();
        exp_pts.push_back(origin);
        t = 0; hit = 1'b0; steps = 0; t_out = '0; fin = 1'b0;
        for (int k = 0; k < MAX_STEPS && !fin; k++) begin
            d     = longint'($signed(dists[k]));
            steps = k + 1;
            if (d < HIT_EPS_L) begin
                hit = 1'b1; fin = 1'b1;
            end else begin
                tn = t + d;
                if (tn > SAT_L) tn = SAT_L;
                t = tn;
                if (tn > MAX_DIST_L || steps == MAX_STEPS) fin = 1'b1;
                else exp_pts.push_back(point_at(origin, dir, tn));
            end
        end
        t_out = t[31:0];
    endtask

    // Drives one ray, answers every strobe after 'lat' cycles, then holds off res_ready.
    task automatic apply_stimulus(input vec3_t origin, input vec3_t dir, input dist4_t dists,
                                  input int lat, input int ready_delay);
        int         k, waited;
        bit         fin;
        logic [39:0] cap;
        obs_pts.delete();
        strobes = 0;
        check_output("ray_ready_idle", ray_ready, 1);
        ray_valid = 1'b1; ray_origin = origin; ray_dir = dir;
        tick();
        ray_valid = 1'b0;
        check_output("first_strobe", sdf_valid, 1);
        k = 0; fin = 1'b0;
        for (int it = 0; it < 16 && !fin; it++) begin
            waited = 0;
            while (!sdf_valid && !res_valid && waited < 200) begin
                tick();
                waited++;
            end
            if (waited >= 200) begin
                check_output("timeout", 0, 1);
                got_hit = 1'bx; got_t = 'x; got_steps = -1;
                return;
            end
            if (res_valid) begin
                fin = 1'b1;
            end else begin
                obs_pts.push_back(sdf_point);
                repeat (lat) tick();
                sdf_dist_valid = 1'b1;
                sdf_dist = dists[(k < 4) ? k : 3];
                k++;
                tick();
                sdf_dist_valid = 1'b0;
            end
        end
        got_hit = res_hit; got_t = res_t; got_steps = int'(res_steps);
        check_output("ray_ready_busy", ray_ready, 0);
        cap = {res_hit, res_t, res_steps};
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            check_output("res_stable", {res_valid, ray_ready, res_hit, res_t, res_steps}, {2'b10, cap});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_output("res_released", {res_valid, ray_ready}, 2'b01);
    endtask

    task automatic verify(input string tag, input logic exp_hit, input logic [31:0] exp_t, input int exp_steps);
        check_output({tag, " res_hit"}, got_hit, exp_hit);
        check_output({tag, " res_t"}, got_t, exp_t);
        check_output({tag, " res_steps"}, got_steps, exp_steps);
        check_output({tag, " strobes"}, strobes, exp_steps);
        check_output({tag, " point_count"}, obs_pts.size(), exp_pts.size());
        for (int i = 0; i < exp_pts.size() && i < obs_pts.size(); i++)
            check_output($sformatf("%s point%0d", tag, i), obs_pts[i], exp_pts[i]);
    endtask

    function automatic logic [31:0] rand_dist();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'($urandom_range(0, 32'h40));
        if (r == 1) return -32'($urandom_range(1, 32'h1_0000));
        if (r == 2) return 32'($urandom_range(32'h10_0000, 32'h30_0000));
        return 32'($urandom_range(32'h41, 32'h8_0000));
    endfunction

    function automatic logic [31:0] rand_fp(input int span);
        return 32'(int'($urandom_range(0, 2 * span)) - span);
    endfunction

    initial begin
        logic        m_hit;
        logic [31:0] m_t;
        int          m_steps;
        vec3_t       o, d;
        dist4_t      ds;

        checks = 0; passes = 0; strobes = 0;
        rst_n = 1'b0; ray_valid = 1'b0; ray_origin = '0; ray_dir = '0;
        sdf_dist = '0; sdf_dist_valid = 1'b0; res_ready = 1'b0;

        tbl[0] = '{v3(32'h1_0000, 0, 0), v3(0, 0, 32'h1_0000), d4(32'hFFFF_C000, 0, 0, 0), 1, 1'b1, 32'h0, 1};
        tbl[1] = '{v3(0, 0, 32'hFFFB_0000), v3(0, 0, 32'h1_0000), d4(32'h2_0000, 32'h1_0000, 32'h20, 0), 1, 1'b1, 32'h3_0000, 3};
        tbl[2] = '{v3(32'h1_0000, 32'h2_0000, 32'h3_0000), v3(32'h1_0000, 0, 0), d4(32'h8000, 32'h8000, 32'h8000, 32'h8000), 2, 1'b0, 32'h2_0000, 4};
        tbl[3] = '{v3(0, 0, 0), v3(0, 32'h1_0000, 0), d4(32'h28_0000, 32'h28_0000, 32'h28_0000, 0), 1, 1'b0, 32'h50_0000, 2};
        tbl[4] = '{v3(32'h5000, 0, 0), v3(32'h8000, 32'h8000, 0), d4(32'h40_0000, 32'h41, 32'h1_0000, 0), 3, 1'b0, 32'h40_0041, 2};
        tbl[5] = '{v3(0, 32'hFFFF_8000, 0), v3(0, 0, 32'hFFFF_0000), d4(32'h1_0000, 32'h40, 32'h1_0000, 0), 1, 1'b1, 32'h1_0000, 2};
        tbl[6] = '{v3(0, 0, 0), v3(0, 32'h1_0000, 0), d4(32'h1_0000, 32'h7FFF_FFFF, 0, 0), 2, 1'b0, 32'h7FFF_FFFF, 2};

        repeat (2) @(negedge clk);
        check_output("reset ctl", {ray_ready, sdf_valid, res_valid, res_hit}, 4'b1000);
        check_output("reset data", {sdf_point, res_t, res_steps}, '0);
        rst_n = 1'b1;
        tick();
        check_output("post_reset ready", ray_ready, 1);

        sdf_dist_valid = 1'b1; sdf_dist = 32'hFFFF_0000;
        tick();
        sdf_dist_valid = 1'b0;
        tick();
        check_output("spurious ignored", {ray_ready, sdf_valid, res_valid}, 3'b100);

        for (int i = 0; i < 7; i++) begin
            model_ray(tbl[i].origin, tbl[i].dir, tbl[i].dists, m_hit, m_t, m_steps);
            apply_stimulus(tbl[i].origin, tbl[i].dir, tbl[i].dists, tbl[i].lat, 0);
            verify($sformatf("row%0d", i), tbl[i].hit, tbl[i].t, tbl[i].steps);
        end

        // Slow SDF plus a stalled consumer, then a back-to-back ray.
        model_ray(tbl[1].origin, tbl[1].dir, tbl[1].dists, m_hit, m_t, m_steps);
        apply_stimulus(tbl[1].origin, tbl[1].dir, tbl[1].dists, 5, 6);
        verify("backpressure", 1'b1, 32'h3_0000, 3);
        model_ray(tbl[2].origin, tbl[2].dir, tbl[2].dists, m_hit, m_t, m_steps);
        apply_stimulus(tbl[2].origin, tbl[2].dir, tbl[2].dists, 1, 0);
        verify("back_to_back", 1'b0, 32'h2_0000, 4);

        for (int r = 0; r < 40; r++) begin
            o = v3(rand_fp(32'h10_0000), rand_fp(32'h10_0000), rand_fp(32'h10_0000));
            d = v3(rand_fp(32'h1_0000), rand_fp(32'h1_0000), rand_fp(32'h1_0000));
            for (int j = 0; j < 4; j++) ds[j] = rand_dist();
            model_ray(o, d, ds, m_hit, m_t, m_steps);
            apply_stimulus(o, d, ds, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            verify($sformatf("rand%0d", r), m_hit, m_t, m_steps);
        end

        model_ray(tbl[1].origin, tbl[1].dir, tbl[1].dists, m_hit, m_t, m_steps);
        apply_stimulus(tbl[1].origin, tbl[1].dir, tbl[1].dists, 1, 0);
        verify("pre_abort", 1'b1, 32'h3_0000, 3);
        ray_valid = 1'b1; ray_origin = v3(32'h3_0000, 32'h4_0000, 32'h5_0000); ray_dir = v3(0, 0, 32'h1_0000);
        tick();
        ray_valid = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        check_output("abort ctl", {ray_ready, sdf_valid, res_valid, res_hit}, 4'b1000);
        check_output("abort data", {sdf_point, res_t, res_steps}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sdf_dist_valid = 1'b1; sdf_dist = 32'h2_0000;
        tick();
        sdf_dist_valid = 1'b0;
        repeat (3) begin
            tick();
            check_output("late valid ignored", {ray_ready, sdf_valid, res_valid, res_t}, {3'b100, 32'h0});
        end
        model_ray(tbl[3].origin, tbl[3].dir, tbl[3].dists, m_hit, m_t, m_steps);
        apply_stimulus(tbl[3].origin, tbl[3].dir, tbl[3].dists, 1, 1);
        verify("post_abort", 1'b0, 32'h50_0000, 2);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
